// File: rtl/result_drain_if.sv
// Handshake and data bundle between the systolic controller, result_drain and the consumer.
interface result_drain_if #(
    parameter int W = 32,
    parameter int N = 3
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic                i_start;
    logic [W*N*N-1:0]    i_C;
    logic                i_ready;
    logic [W-1:0]        o_data;
    logic                o_valid;
    logic [RW-1:0]       o_row;
    logic [RW-1:0]       o_col;
    logic                o_last;
    logic                o_busy;
    logic                o_done;
    logic                o_overrun;

    modport slave (
        input  i_start, i_C, i_ready,
        output o_data, o_valid, o_row, o_col, o_last, o_busy, o_done, o_overrun
    );

    modport master (
        output i_start, i_C, i_ready,
        input  o_data, o_valid, o_row, o_col, o_last, o_busy, o_done, o_overrun
    );
endinterface

// File: rtl/result_drain.sv
// Waits LAT cycles after a compute start, snapshots the N*N result bus and
// streams it row-major over valid/ready with row/column tags.
module result_drain #(
    parameter int W   = 32,
    parameter int N   = 3,
    parameter int LAT = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    result_drain_if.slave  bus
);
    localparam int NN = N * N;
    localparam int KW = (NN > 1) ? $clog2(NN) : 1;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(NN - 1);
    localparam logic [RW-1:0] RC_LAST  = RW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  k_q, k_d;
    logic [RW-1:0]  row_q, row_d;
    logic [RW-1:0]  col_q, col_d;
    logic [W-1:0]   snap_q [NN];
    logic [W-1:0]   snap_d [NN];
    logic           done_q, done_d;
    logic           overrun_q, overrun_d;
    logic           stream;
    logic           accept;

    assign stream = (state_q == S_STREAM);
    assign accept = stream && bus.i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            snap_q    <= '{default: '0};
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            row_q     <= row_d;
            col_q     <= col_d;
            snap_q    <= snap_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        snap_d    = snap_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        // A start seen in any non-idle state, including the final handshake edge, is dropped.
        if (bus.i_start && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_STREAM;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    for (int unsigned i = 0; i < NN; i++) begin
                        snap_d[i] = bus.i_C[i*W +: W];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STREAM: begin
                if (accept) begin
                    if (k_q == K_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                        if (col_q == RC_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_valid   = stream;
        bus.o_data    = stream ? snap_q[k_q] : '0;
        bus.o_row     = stream ? row_q : '0;
        bus.o_col     = stream ? col_q : '0;
        bus.o_last    = stream && (k_q == K_LAST);
        bus.o_busy    = (state_q != S_IDLE);
        bus.o_done    = done_q;
        bus.o_overrun = overrun_q;
    end
endmodule

// File: doc/result_drain.md
# result_drain

Downstream stage of the N×N systolic matrix-multiply controller. After a compute is launched, the block waits a fixed number of cycles, then takes a snapshot of the flattened result bus C. It streams the N·N result elements out one per handshake over a valid/ready interface, in row-major order with row/column tags. The snapshot frees the array for the next operation while results drain.

## Interface
- W, 32, element width in bits.
- N, 3, matrix dimension; the bus carries N·N elements.
- LAT, 8, number of cycles from the start edge to the edge where i_C is valid and captured; legal range is 1 or greater.

- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle pulse, coincident with the cycle the upstream controller starts a compute.
- i_C  in  W·N·N  flattened result from the controller; element k = r·N+c occupies bits [k·W+W-1 : k·W].
- o_data  out  W  current element.
- o_valid  out  1  o_data, o_row, o_col and o_last are valid.
- i_ready  in  1  consumer accepts when o_valid and i_ready are both high at a rising edge.
- o_row  out  clog2(N) (min 1)  row index of o_data.
- o_col  out  clog2(N) (min 1)  column index of o_data.
- o_last  out  1  high with the final element, r=c=N-1.
- o_busy  out  1  high in WAIT or STREAM.
- o_done  out  1  one-cycle pulse after the last element is accepted.
- o_overrun  out  1  sticky; set when i_start arrives while busy.

## Operation
- States:
  - IDLE: o_valid=0, o_busy=0.
  - WAIT: wait counter running, o_busy=1.
  - STREAM: o_valid=1, o_busy=1.
- IDLE → WAIT: i_start=1 at an edge. The wait counter loads LAT-1.
- WAIT: the counter decrements each edge. At the edge where the counter equals 0:
  - capture snapshot <= i_C;
  - set element index k <= 0;
  - go to STREAM.
- STREAM, each edge with o_valid & i_ready:
  - if k < N·N-1: k <= k+1;
  - else: go to IDLE and assert o_done for exactly the next cycle.
- STREAM outputs:
  - o_data = snapshot element k.
  - o_row = k / N and o_col = k mod N. Keep separate row/column counters; do not divide.
  - o_last = (k == N·N-1).
- Stall: while o_valid=1 and i_ready=0, o_data, o_row, o_col and o_last hold stable. Changes in i_C after capture have no effect.
- i_start while o_busy=1:
  - ignored; state, counter and snapshot are unchanged;
  - o_overrun <= 1, and it stays set until reset.
- i_start on the same edge as the final handshake: also counted as an overrun and ignored. The block returns to IDLE.
- i_ready is a don't-care outside STREAM.
- Reset, asserted at any time including mid-stream:
  - immediately: state=IDLE, k=0, counter=0, snapshot=0;
  - all outputs 0: o_data, o_valid, o_row, o_col, o_last, o_busy, o_done, o_overrun.
  - The partial transfer is abandoned and no o_done is issued.
- Widths:
  - k is clog2(N·N) bits and never exceeds N·N-1.
  - The wait counter is clog2(LAT) bits (min 1) and never underflows.

## Timing
- Start at edge t, meaning i_start is sampled high at t:
  - o_busy=1 from t+.
  - Capture at edge t+LAT.
  - o_valid=1 from t+LAT+.
- Minimum drain, with i_ready held at 1: N·N cycles of o_valid. o_done is high in the cycle after the final handshake.
- Back-to-back: the earliest accepted next start is the edge after o_busy falls, i.e. the o_done cycle.
- Throughput: one element per cycle when i_ready=1; no bubbles inside a stream.
- All outputs are registered or derived from registered state only. There is no combinational path from i_ready or i_C to any output.

## Test plan
- Basic drain (N=3, LAT=8, element k = k+1): pulse i_start at edge 0, i_ready=1 → o_valid rises after edge 8; o_data sequence 1..9 with (row,col) = (0,0)..(2,2); o_last only on 9; o_done one cycle after; o_overrun=0.
- Backpressure: i_ready toggles 1,0,0,1,… during stream → each element is held stable while stalled; all 9 values delivered exactly once, in order.
- Snapshot isolation: change i_C to all 0xFFFFFFFF one cycle after capture → the streamed values are still the captured 1..9.
- Overrun: pulse i_start again in WAIT and again mid-STREAM → the stream is unaffected; o_overrun=1 from the first extra pulse and stays 1 until reset.
- Reset mid-stream: assert i_rst after the 4th accepted element → all outputs 0 immediately and no o_done; a new start then streams from (0,0).
- LAT=1 edge case: i_start at edge 0 → capture at edge 1 and o_valid at edge 1+; an immediate restart in the o_done cycle is accepted.
